led_frame_sequencer: RTL

LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

---
 rtl/led_frame_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/led_frame_sequencer.sv
// Double-buffered LED frame sequencer: IDLE -> LOAD -> SEND -> GAP.
// Optional auto-refresh of the active frame is enabled by defining LED_AUTO_REFRESH_EN.
module led_frame_sequencer #(
  parameter int unsigned NUM_LEDS       = 6,
  parameter int unsigned GAP_CYCLES     = 32,
  parameter int unsigned REFRESH_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [2:0]              wr_idx,
  input  logic [23:0]             wr_color,
  input  logic                    commit,
  input  logic                    done,
  output logic [24*NUM_LEDS-1:0]  color_string,
  output logic                    load,
  output logic                    busy,
  output logic                    wr_err
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_e;

  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [3:0]      IdxLim  = 4'(NUM_LEDS);

  state_e            state_q;
  logic [23:0]       shadow_q [NUM_LEDS];
  logic [23:0]       shadow_d [NUM_LEDS];
  logic [23:0]       active_q [NUM_LEDS];
  logic              pending_q;
  logic              wr_err_q;
  logic              done_q;
  logic              load_q;
  logic              busy_q;
  logic [GapW-1:0]   gap_q;
  logic              wr_valid;
  logic              refresh_due;

  assign wr_valid = wr_en && ({1'b0, wr_idx} < IdxLim);

  // The copy into the active frame uses shadow_d so a same-cycle write is included.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_valid) begin
      shadow_d[wr_idx] = wr_color;
    end
  end

`ifdef LED_AUTO_REFRESH_EN
  localparam int unsigned RefW = $clog2(REFRESH_CYCLES + 1);
  logic [RefW-1:0] refresh_q;

  assign refresh_due = (refresh_q == RefW'(REFRESH_CYCLES - 1));

  // Counts consecutive quiet IDLE cycles; any departure from IDLE restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_q <= '0;
    end else if (state_q != IDLE || commit || pending_q || refresh_due) begin
      refresh_q <= '0;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end
`else
  logic unused_refresh;
  assign unused_refresh = (REFRESH_CYCLES == 0);
  assign refresh_due    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      pending_q <= 1'b0;
      wr_err_q  <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      gap_q     <= '0;
    end else begin
      shadow_q <= shadow_d;
      done_q   <= done;
      load_q   <= 1'b0;
      if (wr_en && !wr_valid) begin
        wr_err_q <= 1'b1;
      end
      if (commit && state_q != IDLE) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (commit || pending_q) begin
            active_q  <= shadow_d;
            pending_q <= 1'b0;
            state_q   <= LOAD;
            load_q    <= 1'b1;
            busy_q    <= 1'b1;
          end else if (refresh_due) begin
            state_q <= LOAD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= SEND;
        end
        SEND: begin
          // Only a fresh low-to-high transition of done ends the frame.
          if (done && !done_q) begin
            state_q <= GAP;
            gap_q   <= '0;
          end
        end
        GAP: begin
          if (gap_q == GapLast) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < int'(NUM_LEDS); i++) begin : g_pack
    assign color_string[24*(int'(NUM_LEDS)-i)-1 -: 24] = active_q[i];
  end

  assign load   = load_q;
  assign busy   = busy_q;
  assign wr_err = wr_err_q;

endmodule
